// File: rtl/store_aligner_pkg.sv
// rtl/store_aligner_pkg.sv - shared types and helpers for the store aligner
package store_aligner_pkg;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef enum logic {BEAT0, BEAT1} beat_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    msize_t      size;
  } entry_t;

  function automatic logic [3:0] msize_bytes(input msize_t s);
    case (s)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - places right-justified store data into a 2*NB byte lane window
module store_lane_gen
  import store_aligner_pkg::*;
#(
  parameter int NB = 8
) (
  input  logic [$clog2(NB)-1:0] offset,
  input  msize_t                size,
  input  logic [63:0]           data,
  output logic [16*NB-1:0]      wide_data,
  output logic [2*NB-1:0]       wide_strobe
);

  logic [7:0]  byte_mask;
  logic [63:0] data_mask;

  always_comb begin
    byte_mask = 8'h00;
    data_mask = '0;
    case (size)
      MSIZE1:  begin byte_mask = 8'h01; data_mask = 64'h0000_0000_0000_00ff; end
      MSIZE2:  begin byte_mask = 8'h03; data_mask = 64'h0000_0000_0000_ffff; end
      MSIZE4:  begin byte_mask = 8'h0f; data_mask = 64'h0000_0000_ffff_ffff; end
      default: begin byte_mask = 8'hff; data_mask = 64'hffff_ffff_ffff_ffff; end
    endcase
  end

  // Masking first keeps lanes outside the strobe at zero even if the upper data bits are dirty.
  assign wide_data   = {{(16*NB-64){1'b0}}, data & data_mask} << {offset, 3'b000};
  assign wide_strobe = {{(2*NB-8){1'b0}}, byte_mask} << offset;

endmodule

// File: rtl/store_aligner.sv
// rtl/store_aligner.sv - buffers store requests and emits one or two lane-aligned write beats each
module store_aligner
  import store_aligner_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 2,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              split_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [63:0]       in_data,
  input  msize_t            in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [NB-1:0]     out_strobe,
  output logic              out_last,
  output logic              err,
  output logic [CW-1:0]     count
);

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  beat_state_t       state_q, state_d;
  logic              err_q, err_d;
  logic              ready_en_q, ready_en_d;

  entry_t            head;
  logic [OW:0]       in_end, head_end;
  logic              in_cross, head_cross, accept, push, pop, beat_hs;
  logic [16*NB-1:0]  wide_data;
  logic [2*NB-1:0]   wide_strobe;
  logic [ADDR_W-1:0] base_addr;

  assign head       = mem_q[rd_ptr_q];
  assign in_end     = {1'b0, in_addr[OW-1:0]} + (OW+1)'(msize_bytes(in_size));
  assign in_cross   = in_end > (OW+1)'(NB);
  assign head_end   = {1'b0, head.addr[OW-1:0]} + (OW+1)'(msize_bytes(head.size));
  assign head_cross = head_end > (OW+1)'(NB);

  store_lane_gen #(.NB(NB)) u_lane_gen (
    .offset      (head.addr[OW-1:0]),
    .size        (head.size),
    .data        (head.data),
    .wide_data   (wide_data),
    .wide_strobe (wide_strobe)
  );

  // in_ready stays low through reset and the first cycle after release.
  assign in_ready   = ready_en_q && (count_q != CW'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign base_addr  = head.addr[ADDR_W-1:0] & ~ADDR_W'(NB - 1);
  assign out_addr   = (state_q == BEAT1) ? base_addr + ADDR_W'(NB) : base_addr;
  assign out_data   = (state_q == BEAT1) ? wide_data[16*NB-1:DATA_W] : wide_data[DATA_W-1:0];
  assign out_strobe = (state_q == BEAT1) ? wide_strobe[2*NB-1:NB] : wide_strobe[NB-1:0];
  assign out_last   = !head_cross || (state_q == BEAT1);
  assign err        = err_q;
  assign count      = count_q;

  assign accept  = in_valid && in_ready;
  assign push    = accept && !(in_cross && !split_en);
  assign beat_hs = out_valid && out_ready;
  assign pop     = beat_hs && out_last;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    ready_en_d = 1'b1;
    err_d      = accept && in_cross && !split_en;
    count_d    = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = '{addr: 64'(in_addr), data: in_data, size: in_size};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (beat_hs) state_d = (state_q == BEAT0 && head_cross) ? BEAT1 : BEAT0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= BEAT0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      err_q      <= err_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
// tb/tb_store_aligner.sv - directed self-checking bench for store_aligner (DATA_W=64, DEPTH=2)
module tb_store_aligner;
  import store_aligner_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        split_en;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [63:0] in_data;
  msize_t      in_size;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_addr;
  logic [63:0] out_data;
  logic [7:0]  out_strobe;
  logic        out_last;
  logic        err;
  logic [1:0]  count;

  int checks = 0;
  int failures = 0;

  store_aligner #(.DATA_W(64), .ADDR_W(64), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .split_en   (split_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_size    (in_size),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_strobe (out_strobe),
    .out_last   (out_last),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] d, input msize_t s);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s, input logic l);
    check({tag, ".valid"},  64'(out_valid),  64'd1);
    check({tag, ".addr"},   out_addr,        a);
    check({tag, ".data"},   out_data,        d);
    check({tag, ".strobe"}, 64'(out_strobe), 64'(s));
    check({tag, ".last"},   64'(out_last),   64'(l));
  endtask

  initial begin
    rst_n = 1'b0; split_en = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    in_size = MSIZE1; out_ready = 1'b0;
    #12;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.count",     64'(count),     64'd0);
    check("rst.err",       64'(err),       64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle.in_ready", 64'(in_ready), 64'd1);

    // aligned doubleword
    drive(64'h8000_0008, 64'h1122_3344_5566_7788, MSIZE8);
    tick(); in_valid = 1'b0;
    check_beat("sd", 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hff, 1'b1);
    check("sd.count", 64'(count), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("sd.drained", 64'(out_valid), 64'd0);

    // byte store, dirty upper data bits must not leak
    drive(64'h8000_0003, 64'hFFFF_FFFF_FFFF_FFAB, MSIZE1);
    tick(); in_valid = 1'b0;
    check_beat("sb", 64'h8000_0000, 64'h0000_0000_AB00_0000, 8'h08, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("sb.count", 64'(count), 64'd0);

    // crossing word store, split
    split_en = 1'b1;
    drive(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, MSIZE4);
    tick(); in_valid = 1'b0;
    check_beat("sw.b0", 64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hc0, 1'b0);
    out_ready = 1'b1; tick();
    check("sw.count_b1", 64'(count), 64'd1);
    check_beat("sw.b1", 64'h8000_0008, 64'h0000_0000_0000_DEAD, 8'h03, 1'b1);
    tick(); out_ready = 1'b0;
    check("sw.count_end", 64'(count), 64'd0);
    check("sw.valid_end", 64'(out_valid), 64'd0);

    // crossing word store, rejected
    split_en = 1'b0;
    drive(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, MSIZE4);
    tick(); in_valid = 1'b0;
    check("rej.err",   64'(err),       64'd1);
    check("rej.valid", 64'(out_valid), 64'd0);
    check("rej.count", 64'(count),     64'd0);
    tick();
    check("rej.err_pulse", 64'(err), 64'd0);
    split_en = 1'b1;

    // backpressure
    drive(64'h8000_0010, 64'h0000_0000_0000_1234, MSIZE2);
    tick();
    drive(64'h8000_0022, 64'h0000_0000_0000_5678, MSIZE2);
    tick();
    check("bp.count_full",  64'(count),    64'd2);
    check("bp.in_ready_lo", 64'(in_ready), 64'd0);
    drive(64'h8000_0031, 64'h0000_0000_0000_009A, MSIZE1);
    tick();
    check("bp.count_held", 64'(count), 64'd2);
    check_beat("bp.hold", 64'h8000_0010, 64'h0000_0000_0000_1234, 8'h03, 1'b1);
    out_ready = 1'b1; tick();
    check("bp.count_pop1",  64'(count),    64'd1);
    check("bp.in_ready_hi", 64'(in_ready), 64'd1);
    check_beat("bp.second", 64'h8000_0020, 64'h0000_0000_5678_0000, 8'h0c, 1'b1);
    tick(); in_valid = 1'b0;
    check("bp.count_pushpop", 64'(count), 64'd1);
    check_beat("bp.third", 64'h8000_0030, 64'h0000_0000_0000_9A00, 8'h02, 1'b1);
    tick(); out_ready = 1'b0;
    check("bp.count_end", 64'(count), 64'd0);

    // reset while beat 1 pending
    drive(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, MSIZE4);
    tick(); in_valid = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("mid.pre_last", 64'(out_last), 64'd1);
    rst_n = 1'b0; #1;
    check("mid.valid", 64'(out_valid), 64'd0);
    check("mid.count", 64'(count),     64'd0);
    #3; rst_n = 1'b1;
    tick(); tick();
    drive(64'h8000_0005, 64'h0000_0000_0000_0077, MSIZE1);
    tick(); in_valid = 1'b0;
    check_beat("post", 64'h8000_0000, 64'h0000_7700_0000_0000, 8'h20, 1'b1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("post.count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_aligner.md
# store_aligner

Parametrised store-path aligner between the memory stage and the data-bus request port. It accepts right-justified store requests (address, data, size) through a valid/ready handshake and buffers them in a small in-order FIFO. Each request becomes one or two bus-width write beats with byte-lane-aligned data and strobe. Unlike the single-cycle 64-bit lane placer, it generalises bus width and buffering, and either splits stores that cross a bus-word boundary into two beats or rejects them with an error pulse.

## Interface
- DATA_W, 64, bus data width in bits; power of two, 64..512; NB = DATA_W/8 bytes per beat
- ADDR_W, 64, address width
- DEPTH, 2, request FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- split_en  in  1  1: split boundary-crossing stores into two beats; 0: reject them
- in_valid  in  1  store request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_addr  in  ADDR_W  byte address
- in_data  in  64  store data, right-justified
- in_size  in  msize_t  MSIZE1/2/4/8 (1/2/4/8 bytes)
- out_valid  out  1  write beat valid
- out_ready  in  1  beat consumed when out_valid && out_ready
- out_addr  out  ADDR_W  beat address, aligned to NB
- out_data  out  DATA_W  lane-aligned data; unused lanes 0
- out_strobe  out  NB  byte enables
- out_last  out  1  final beat of the current request
- err  out  1  one-cycle pulse: crossing store rejected
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Per request: off = addr mod NB, n = size bytes, cross = (off + n > NB).
- Lane math over a 2·NB-byte window: data shifted left by off·8, strobe ((1<<n)−1)<<off. The lower NB bytes form beat 0 at addr & ~(NB−1). The upper NB bytes form beat 1 at that address + NB, only when cross.
- Accept with cross && !split_en: nothing enqueued; err = 1 on the next cycle only; count unchanged.
- All other accepts enqueue {addr, data, size} at the write pointer.
- Output FSM on the FIFO head:
  - BEAT0 → BEAT1 on handshake when cross.
  - BEAT0 → BEAT0 with pop on handshake when !cross.
  - BEAT1 → BEAT0 with pop on handshake.
- out_last = !cross || state == BEAT1.
- Pointers wrap modulo DEPTH. Requests drain strictly in order, and beats of different requests never interleave.
- Beat data and strobe are built only from the head entry. Lanes outside the strobe are driven 0.

## Timing
- Reset (asynchronous, while low): count 0, both pointers 0, FSM BEAT0, err 0, out_valid 0, in_ready 0.
- After reset release: in_ready = (count != DEPTH).
- Accept-to-output latency is 1 cycle: a request accepted at edge t into an empty FIFO gives out_valid high after t. There is no combinational in→out path.
- out_valid = (count != 0). The out_* signals are combinational from the head entry and FSM state, and stay stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged. When full, in_ready = 0, and a pop that cycle does not re-open in_ready until the next cycle.
- A crossing store holds its FIFO slot until the BEAT1 handshake.
- Throughput is one beat per cycle with out_ready held high.
- split_en is sampled at accept time; changing it affects only later requests.
- Reset mid-split discards the pending beat 1 and all buffered entries.

## Structure
- Shared package (common) gains:
  - a function giving bytes per msize_t
  - a typedef for the FIFO entry struct {addr, data, size}
- Sub-module store_lane_gen: combinational; inputs offset, size, data; outputs the 2·NB-byte data and strobe. The top level holds the FIFO, pointers, FSM, and err register.

## Test plan
All scenarios use DATA_W=64, DEPTH=2.
- Aligned sd: addr 0x80000008, data 0x1122334455667788, MSIZE8 → one cycle later a single beat: addr 0x80000008, data 0x1122334455667788, strobe 0xff, out_last 1.
- sb: addr 0x80000003, data 0xAB → addr 0x80000000, data 0x00000000AB000000, strobe 0x08, out_last 1.
- Crossing sw with split_en=1: addr 0x80000006, data 0xDEADBEEF →
  - beat 0: addr 0x80000000, data 0xBEEF000000000000, strobe 0xc0, out_last 0
  - beat 1: addr 0x80000008, data 0x000000000000DEAD, strobe 0x03, out_last 1
  - count drops only after beat 1.
- Same store with split_en=0 → no beat, err high exactly one cycle, count stays 0.
- Backpressure with out_ready=0:
  - two sh accepted; in_ready 0 at count 2; a third request is held; out_* stable.
  - out_ready=1 → beats in order; in_ready returns the cycle after the first pop.
- Reset low after the beat-0 handshake of a crossing store → out_valid 0 and count 0 immediately. After release, a new sb emits a single beat with out_last 1.
